// File: rtl/rf_bank_arbiter.sv
// Register-file bank arbiter: per-bank round-robin grant, registered bank read, and writeback tag.
// Optional macro RF_ARB_CONFLICT_CNT_EN enables the saturating bank-conflict cycle counter.
module rf_bank_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  req_valid,
    input  logic [15:0] req_bank,
    input  logic [23:0] req_row,
    output logic [7:0]  req_grant,
    output logic [3:0]  bank_rd_en,
    output logic [11:0] bank_rd_row,
    output logic [3:0]  wb_valid,
    output logic [11:0] wb_req_id,
    output logic [15:0] conflict_cnt
);

    logic [2:0]  ptr [4];
    logic [3:0]  bank_hit;
    logic [11:0] hit_idx;
    logic [11:0] hit_row;
    logic [11:0] rd_id;
    logic [2:0]  idx;

    // Search each bank from its pointer upward with wrap; idx fields stay 0 when a bank is idle.
    always_comb begin
        bank_hit  = '0;
        hit_idx   = '0;
        hit_row   = '0;
        req_grant = '0;
        idx       = '0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                idx = ptr[b] + 3'(i);
                if (!bank_hit[b] && req_valid[idx] && req_bank[{idx, 1'b0} +: 2] == 2'(b)) begin
                    bank_hit[b]      = 1'b1;
                    hit_idx[3*b +: 3] = idx;
                    hit_row[3*b +: 3] = req_row[{2'b00, idx} * 5'd3 +: 3];
                end
            end
            if (bank_hit[b]) begin
                req_grant[hit_idx[3*b +: 3]] = 1'b1;
            end
        end
        if (rst) begin
            req_grant = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                ptr[b] <= '0;
            end
            bank_rd_en  <= '0;
            bank_rd_row <= '0;
            rd_id       <= '0;
            wb_valid    <= '0;
            wb_req_id   <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (bank_hit[b]) begin
                    ptr[b] <= hit_idx[3*b +: 3] + 3'd1;
                end
            end
            bank_rd_en  <= bank_hit;
            bank_rd_row <= hit_row;
            rd_id       <= hit_idx;
            // One-cycle bank read latency: writeback tag trails the read enable by one stage.
            wb_valid    <= bank_rd_en;
            wb_req_id   <= rd_id;
        end
    end

`ifdef RF_ARB_CONFLICT_CNT_EN
    logic [3:0] bank_req_cnt [4];
    logic       any_conflict;

    always_comb begin
        any_conflict = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bank_req_cnt[b] = '0;
            for (int r = 0; r < 8; r++) begin
                if (req_valid[r] && req_bank[2*r +: 2] == 2'(b)) begin
                    bank_req_cnt[b] = bank_req_cnt[b] + 4'd1;
                end
            end
            if (bank_req_cnt[b] >= 4'd2) begin
                any_conflict = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (any_conflict && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_rf_bank_arbiter.sv
// Directed bench for rf_bank_arbiter; conflict counter checks follow RF_ARB_CONFLICT_CNT_EN.
module tb_rf_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  req_valid = '0;
    logic [15:0] req_bank = '0;
    logic [23:0] req_row = '0;
    logic [7:0]  req_grant;
    logic [3:0]  bank_rd_en;
    logic [11:0] bank_rd_row;
    logic [3:0]  wb_valid;
    logic [11:0] wb_req_id;
    logic [15:0] conflict_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    rf_bank_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_bank     (req_bank),
        .req_row      (req_row),
        .req_grant    (req_grant),
        .bank_rd_en   (bank_rd_en),
        .bank_rd_row  (bank_rd_row),
        .wb_valid     (wb_valid),
        .wb_req_id    (wb_req_id),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_bank  = '0;
        req_row   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int r, input logic [1:0] bank, input logic [2:0] row);
        req_valid[r]       = 1'b1;
        req_bank[2*r +: 2] = bank;
        req_row[3*r +: 3]  = row;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 8'hFF;
        #1;
        n_checks++;
        if (req_grant !== 8'h00) begin
            n_fail++; $display("FAIL reset_grant: got %h expected 00", req_grant);
        end
        tick();
        tick();
        n_checks++;
        if ({bank_rd_en, bank_rd_row, wb_valid, wb_req_id} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: rd_en=%h row=%h wb=%h id=%h expected all 0",
                     bank_rd_en, bank_rd_row, wb_valid, wb_req_id);
        end
        n_checks++;
        if (conflict_cnt !== 16'h0) begin
            n_fail++; $display("FAIL reset_cnt: got %h expected 0000", conflict_cnt);
        end
        clear_reqs();
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 2'd0, 3'd5);
        #1;
        n_checks++;
        if (req_grant !== 8'h01) begin
            n_fail++; $display("FAIL single_grant: got %h expected 01", req_grant);
        end
        tick();
        clear_reqs();
        n_checks++;
        if (bank_rd_en !== 4'b0001 || bank_rd_row !== 12'd5 || wb_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_read: rd_en=%b row=%h wb=%b expected 0001 005 0000",
                     bank_rd_en, bank_rd_row, wb_valid);
        end
        tick();
        n_checks++;
        if (wb_valid !== 4'b0001 || wb_req_id !== 12'h000 || bank_rd_en !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_wb: wb=%b id=%h rd_en=%b expected 0001 000 0000",
                     wb_valid, wb_req_id, bank_rd_en);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_g [5];
        exp_g = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h01};
        do_reset();
        set_req(0, 2'd1, 3'd1);
        set_req(2, 2'd1, 3'd2);
        set_req(4, 2'd1, 3'd3);
        set_req(6, 2'd1, 3'd4);
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (req_grant !== exp_g[k]) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got %h expected %h", k, req_grant, exp_g[k]);
            end
            tick();
        end
        n_checks++;
`ifdef RF_ARB_CONFLICT_CNT_EN
        if (conflict_cnt !== 16'd5) begin
            n_fail++; $display("FAIL rr_cnt: got %0d expected 5", conflict_cnt);
        end
`else
        if (conflict_cnt !== 16'd0) begin
            n_fail++; $display("FAIL rr_cnt: got %0d expected 0", conflict_cnt);
        end
`endif
        clear_reqs();
    endtask

    task automatic test_four_banks();
        do_reset();
        set_req(0, 2'd0, 3'd1);
        set_req(3, 2'd1, 3'd2);
        set_req(5, 2'd2, 3'd3);
        set_req(6, 2'd3, 3'd4);
        #1;
        n_checks++;
        if (req_grant !== 8'h69) begin
            n_fail++; $display("FAIL four_grant: got %h expected 69", req_grant);
        end
        tick();
        clear_reqs();
        n_checks++;
        if (bank_rd_en !== 4'hF || bank_rd_row !== 12'h8D1) begin
            n_fail++;
            $display("FAIL four_read: rd_en=%h row=%h expected F 8d1", bank_rd_en, bank_rd_row);
        end
        tick();
        n_checks++;
        if (wb_valid !== 4'hF || wb_req_id !== 12'hD58) begin
            n_fail++;
            $display("FAIL four_wb: wb=%h id=%h expected F d58", wb_valid, wb_req_id);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_req(6, 2'd1, 3'd0);
        #1;
        n_checks++;
        if (req_grant !== 8'h40) begin
            n_fail++; $display("FAIL wrap_setup: got %h expected 40", req_grant);
        end
        tick();
        clear_reqs();
        set_req(1, 2'd1, 3'd2);
        set_req(7, 2'd1, 3'd3);
        #1;
        n_checks++;
        if (req_grant !== 8'h80) begin
            n_fail++; $display("FAIL wrap_first: got %h expected 80", req_grant);
        end
        tick();
        req_valid[7] = 1'b0;
        #1;
        n_checks++;
        if (req_grant !== 8'h02 || bank_rd_row !== 12'h018) begin
            n_fail++;
            $display("FAIL wrap_second: grant=%h row=%h expected 02 018", req_grant, bank_rd_row);
        end
        tick();
        clear_reqs();
        n_checks++;
        if (bank_rd_row !== 12'h010 || wb_req_id !== 12'h038 || wb_valid !== 4'b0010) begin
            n_fail++;
            $display("FAIL wrap_pipe: row=%h id=%h wb=%b expected 010 038 0010",
                     bank_rd_row, wb_req_id, wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_req(2, 2'd2, 3'd1);
        set_req(3, 2'd2, 3'd6);
        #1;
        n_checks++;
        if (req_grant !== 8'h04) begin
            n_fail++; $display("FAIL b2b_first: got %h expected 04", req_grant);
        end
        tick();
        req_valid[2] = 1'b0;
        #1;
        n_checks++;
        if (req_grant !== 8'h08) begin
            n_fail++; $display("FAIL b2b_second: got %h expected 08", req_grant);
        end
        tick();
        clear_reqs();
        n_checks++;
        if (bank_rd_row !== 12'h180 || wb_req_id !== 12'h080 || wb_valid !== 4'b0100) begin
            n_fail++;
            $display("FAIL b2b_pipe1: row=%h id=%h wb=%b expected 180 080 0100",
                     bank_rd_row, wb_req_id, wb_valid);
        end
        tick();
        n_checks++;
        if (wb_req_id !== 12'h0C0 || wb_valid !== 4'b0100 || bank_rd_en !== 4'b0000) begin
            n_fail++;
            $display("FAIL b2b_pipe2: id=%h wb=%b rd_en=%b expected 0c0 0100 0000",
                     wb_req_id, wb_valid, bank_rd_en);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_req(0, 2'd0, 3'd4);
        #1;
        n_checks++;
        if (req_grant !== 8'h01) begin
            n_fail++; $display("FAIL mid_grant: got %h expected 01", req_grant);
        end
        tick();
        clear_reqs();
        rst = 1'b1;
        n_checks++;
        if (bank_rd_en !== 4'b0001) begin
            n_fail++; $display("FAIL mid_read: got %b expected 0001", bank_rd_en);
        end
        tick();
        n_checks++;
        if (wb_valid !== 4'b0000 || bank_rd_en !== 4'b0000 || wb_req_id !== 12'h0) begin
            n_fail++;
            $display("FAIL mid_discard: wb=%b rd_en=%b id=%h expected 0000 0000 000",
                     wb_valid, bank_rd_en, wb_req_id);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (wb_valid !== 4'b0000) begin
            n_fail++; $display("FAIL mid_late_wb: got %b expected 0000", wb_valid);
        end
        // Pointer 0 was advanced to 1 before reset; requester 0 winning shows it returned to 0.
        set_req(0, 2'd0, 3'd0);
        set_req(1, 2'd0, 3'd0);
        #1;
        n_checks++;
        if (req_grant !== 8'h01) begin
            n_fail++; $display("FAIL mid_ptr: got %h expected 01", req_grant);
        end
        clear_reqs();
    endtask

    task automatic test_saturate();
        do_reset();
        set_req(0, 2'd0, 3'd0);
        set_req(1, 2'd0, 3'd0);
`ifdef RF_ARB_CONFLICT_CNT_EN
        repeat (70000) tick();
        n_checks++;
        if (conflict_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_reach: got %h expected ffff", conflict_cnt);
        end
        repeat (10) tick();
        n_checks++;
        if (conflict_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_hold: got %h expected ffff", conflict_cnt);
        end
`else
        repeat (20) tick();
        n_checks++;
        if (conflict_cnt !== 16'h0) begin
            n_fail++; $display("FAIL cnt_disabled: got %h expected 0000", conflict_cnt);
        end
`endif
        clear_reqs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_four_banks();
        test_wrap();
        test_back_to_back();
        test_reset_midflight();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
